// File: rtl/tsr_reg_if.sv
// tsr_reg_if: FIFO read-side handshake between the UART transmit shift
// register and its show-ahead TX FIFO.
//   fifo_empty : FIFO has no data (driven by the FIFO)
//   tdata      : FIFO head byte, valid whenever fifo_empty=0 (driven by the FIFO)
//   rd_en      : one-cycle pop strobe (driven by the transmitter)
// master = transmitter (consumer), slave = FIFO.
interface tsr_reg_if;
  logic       fifo_empty;
  logic [7:0] tdata;
  logic       rd_en;

  modport master (input fifo_empty, input tdata, output rd_en);
  modport slave  (output fifo_empty, output tdata, input rd_en);
endinterface

// File: rtl/tsr_reg.sv
// tsr_reg: UART transmit shift register.
// Pops a byte from a show-ahead TX FIFO and sends it as start bit, 5..8 data
// bits LSB first, optional parity, and 1 or 2 stop bits. Bit time is OSR_A or
// OSR_B ticks of btick_16. The frame format is captured at pop time, so
// changing the inputs mid-frame only affects later frames.
// Ports:
//   btick_16    : oversampling clock, all state on its rising edge
//   rst         : asynchronous active-high reset
//   tx_en       : allow new frames to start
//   tlen        : data length 00=5 .. 11=8 bits
//   parity_en   : append parity bit
//   parity_type : 0 even, 1 odd
//   stop2       : 0 one stop bit, 1 two stop bits
//   sample_type : 0 OSR_A ticks/bit, 1 OSR_B ticks/bit
//   fifo        : FIFO handshake (fifo_empty, tdata in; rd_en out)
//   tx_out      : serial line, registered
//   tx_busy     : frame in progress
//   tx_done     : one-cycle pulse on the last cycle of the stop bit(s)
module tsr_reg #(
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   OSR_A      = 16,
  parameter int   OSR_B      = 13
) (
  input  logic       btick_16,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [1:0] tlen,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       stop2,
  input  logic       sample_type,
  tsr_reg_if.master  fifo,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int OSR_MAX = (OSR_A > OSR_B) ? OSR_A : OSR_B;
  localparam int CW      = (OSR_MAX > 2) ? $clog2(OSR_MAX) : 1;
  localparam logic [CW-1:0] LAST_A = CW'(OSR_A - 1);
  localparam logic [CW-1:0] LAST_B = CW'(OSR_B - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    tlen_q, tlen_d;
  logic          pen_q, pen_d;
  logic          par_q, par_d;
  logic          stop2_q, stop2_d;
  logic          osr_q, osr_d;
  logic          tx_q, tx_d;

  logic          pop, bit_end;
  logic [CW-1:0] cnt_last;
  logic [2:0]    data_last, stop_last;
  logic [7:0]    mask;

  assign cnt_last  = osr_q ? LAST_B : LAST_A;
  assign bit_end   = (cnt_q == cnt_last);
  assign data_last = {1'b0, tlen_q} + 3'd4;   // D-1
  assign stop_last = {2'b00, stop2_q};
  assign mask      = 8'hFF >> (2'd3 - tlen); // keep only the D data bits

  // Pop is qualified by rst so that no strobe reaches the FIFO while reset
  // holds the FSM in IDLE.
  assign pop        = (state_q == S_IDLE) && tx_en && !fifo.fifo_empty && !rst;
  assign fifo.rd_en = pop;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_out     = tx_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tlen_d  = tlen_q;
    pen_d   = pen_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    osr_d   = osr_q;
    tx_done = 1'b0;
    cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        if (pop) begin
          shift_d = fifo.tdata & mask;
          tlen_d  = tlen;
          pen_d   = parity_en;
          par_d   = (^(fifo.tdata & mask)) ^ parity_type;
          stop2_d = stop2;
          osr_d   = sample_type;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == data_last) begin
            bit_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == stop_last) begin
            tx_done = 1'b1;
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is computed from the next state so the flop output matches
    // the current state with no combinational path to the pin.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge btick_16 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tlen_q  <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      osr_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tlen_q  <= tlen_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      osr_q   <= osr_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_tsr_reg.sv
// Directed bench for tsr_reg: frame shapes for several formats, parity,
// back-to-back pops, tx_en drop, empty FIFO and mid-frame reset.
module tb_tsr_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en, parity_en, parity_type, stop2, sample_type;
  logic [1:0] tlen;
  logic       tx_out, tx_busy, tx_done;
  int         total = 0;
  int         bad   = 0;

  tsr_reg_if fif();

  tsr_reg dut (
    .btick_16    (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .tlen        (tlen),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .stop2       (stop2),
    .sample_type (sample_type),
    .fifo        (fif),
    .tx_out      (tx_out),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fmt(input logic [1:0] tl, input logic pe, input logic pt,
                         input logic s2, input logic st, input logic [7:0] d);
    tlen = tl; parity_en = pe; parity_type = pt; stop2 = s2; sample_type = st;
    fif.tdata = d; fif.fifo_empty = 1'b0; tx_en = 1'b1;
  endtask

  // Called at a falling edge with inputs already driven. fr holds the frame
  // bits with fr[0] = start bit, sent in index order, n ticks each.
  task automatic run_frame(input string tag, input logic [11:0] fr, input int nb,
                           input int n, input bit has_next, input logic [7:0] nxt,
                           input bit drop_en, output int w);
    int line_err, busy_err, rd_err, done_cnt, done_at, tot;
    line_err = 0; busy_err = 0; rd_err = 0; done_cnt = 0; done_at = 0;
    tot = nb * n;
    w = 0;
    #1;
    while (fif.rd_en !== 1'b1 && w < 8) begin
      @(negedge clk); #1; w++;
    end
    chk({tag, ":rd_en"}, fif.rd_en, 1'b1);
    chk({tag, ":idle_line"}, tx_out, 1'b1);
    chk({tag, ":idle_busy"}, tx_busy, 1'b0);
    for (int c = 1; c <= tot; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        if (has_next) fif.tdata = nxt;
        else begin
          if (!drop_en) fif.fifo_empty = 1'b1;
          fif.tdata = ~fif.tdata; tlen = ~tlen; parity_en = ~parity_en;
          parity_type = ~parity_type; stop2 = ~stop2; sample_type = ~sample_type;
        end
      end
      if (drop_en && c == 40) tx_en = 1'b0;
      if (tx_out !== fr[(c-1)/n]) line_err++;
      if (tx_busy !== 1'b1) busy_err++;
      if (fif.rd_en !== 1'b0) rd_err++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
    end
    chk({tag, ":line_errs"}, line_err, 0);
    chk({tag, ":busy_errs"}, busy_err, 0);
    chk({tag, ":rd_in_frame"}, rd_err, 0);
    chk({tag, ":done_cycle"}, done_at, tot);
    chk({tag, ":done_count"}, done_cnt, 1);
    @(negedge clk);
  endtask

  task automatic idle_check(input string tag, input int ncyc);
    int err;
    err = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk); #1;
      if (fif.rd_en !== 1'b0 || tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) err++;
    end
    chk({tag, ":idle_errs"}, err, 0);
  endtask

  initial begin
    int w, w2, err;
    rst = 1'b1; tx_en = 1'b0; fif.fifo_empty = 1'b1; fif.tdata = 8'h00;
    tlen = 2'b11; parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; sample_type = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst:tx_out", tx_out, 1'b1);
    chk("rst:busy", tx_busy, 1'b0);
    chk("rst:done", tx_done, 1'b0);
    chk("rst:rd_en", fif.rd_en, 1'b0);
    fif.fifo_empty = 1'b0; tx_en = 1'b1;
    #1 chk("rst:rd_en_gated", fif.rd_en, 1'b0);
    fif.fifo_empty = 1'b1;
    @(negedge clk); rst = 1'b0;
    idle_check("empty_after_rst", 10);
    @(negedge clk);

    // 8N1 16x 0xEB
    set_fmt(2'b11, 0, 0, 0, 0, 8'hEB);
    run_frame("8N1_16x_EB", {2'b00, 1'b1, 8'hEB, 1'b0}, 10, 16, 0, 8'h00, 0, w);
    // 8N1 13x 0xFA
    set_fmt(2'b11, 0, 0, 0, 1, 8'hFA);
    run_frame("8N1_13x_FA", {2'b00, 1'b1, 8'hFA, 1'b0}, 10, 13, 0, 8'h00, 0, w);
    // 8E1 0x22: two ones -> parity 0
    set_fmt(2'b11, 1, 0, 0, 0, 8'h22);
    run_frame("8E1_22", {1'b0, 1'b1, 1'b0, 8'h22, 1'b0}, 11, 16, 0, 8'h00, 0, w);
    // 8O1 0x22 -> parity 1
    set_fmt(2'b11, 1, 1, 0, 0, 8'h22);
    run_frame("8O1_22", {1'b0, 1'b1, 1'b1, 8'h22, 1'b0}, 11, 16, 0, 8'h00, 0, w);
    // 5N2 0xFF: five ones, 32-tick stop, 128 ticks total
    set_fmt(2'b00, 0, 0, 1, 0, 8'hFF);
    run_frame("5N2_FF", {4'b0000, 2'b11, 5'h1F, 1'b0}, 8, 16, 0, 8'h00, 0, w);
    // 7O1 0xC1: bit 7 masked, data 0x41 has two ones -> odd parity 1
    set_fmt(2'b10, 1, 1, 0, 0, 8'hC1);
    run_frame("7O1_C1", {2'b00, 1'b1, 1'b1, 7'h41, 1'b0}, 10, 16, 0, 8'h00, 0, w);

    // back-to-back 0x55 then 0xAA: second pop lands on the cycle after tx_done
    set_fmt(2'b11, 0, 0, 0, 0, 8'h55);
    run_frame("b2b_55", {2'b00, 1'b1, 8'h55, 1'b0}, 10, 16, 1, 8'hAA, 0, w);
    run_frame("b2b_AA", {2'b00, 1'b1, 8'hAA, 1'b0}, 10, 16, 0, 8'h00, 0, w2);
    chk("b2b:gap_161", w2, 0);

    // tx_en dropped mid-frame: frame completes, FIFO stays non-empty, no pop
    set_fmt(2'b11, 0, 0, 0, 0, 8'h0F);
    run_frame("drop_en_0F", {2'b00, 1'b1, 8'h0F, 1'b0}, 10, 16, 0, 8'h00, 1, w);
    idle_check("after_drop", 30);
    tx_en = 1'b1; fif.fifo_empty = 1'b1;
    idle_check("fifo_empty", 20);

    // reset at cycle 40 of a frame (data bit 1 of 0x00 is low)
    @(negedge clk);
    set_fmt(2'b11, 0, 0, 0, 0, 8'h00);
    #1 chk("midrst:rd_en", fif.rd_en, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); #1;
      if (c == 1) fif.fifo_empty = 1'b1;
    end
    chk("midrst:line_before", tx_out, 1'b0);
    chk("midrst:busy_before", tx_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst:line", tx_out, 1'b1);
    chk("midrst:busy", tx_busy, 1'b0);
    chk("midrst:rd_en", fif.rd_en, 1'b0);
    @(negedge clk); rst = 1'b0;
    idle_check("midrst:after", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
